// File: rtl/regfile_pkg.sv
// Shared definitions for the register file slice: default sizes, the
// hardwired-zero register index and MIPS register-name constants.
package regfile_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_NUM_REGS = 32;
  localparam int DEF_ADDR_W   = $clog2(DEF_NUM_REGS);

  // Register index that always reads zero and never becomes pending
  localparam int REG_ZERO = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t ZERO = 5'd0;
  localparam reg_addr_t AT   = 5'd1;
  localparam reg_addr_t V0   = 5'd2;
  localparam reg_addr_t V1   = 5'd3;
  localparam reg_addr_t A0   = 5'd4;
  localparam reg_addr_t A1   = 5'd5;
  localparam reg_addr_t A2   = 5'd6;
  localparam reg_addr_t A3   = 5'd7;
  localparam reg_addr_t T0   = 5'd8;
  localparam reg_addr_t T1   = 5'd9;
  localparam reg_addr_t T2   = 5'd10;
  localparam reg_addr_t T3   = 5'd11;
  localparam reg_addr_t T4   = 5'd12;
  localparam reg_addr_t T5   = 5'd13;
  localparam reg_addr_t T6   = 5'd14;
  localparam reg_addr_t T7   = 5'd15;
  localparam reg_addr_t S0   = 5'd16;
  localparam reg_addr_t S1   = 5'd17;
  localparam reg_addr_t S2   = 5'd18;
  localparam reg_addr_t S3   = 5'd19;
  localparam reg_addr_t S4   = 5'd20;
  localparam reg_addr_t S5   = 5'd21;
  localparam reg_addr_t S6   = 5'd22;
  localparam reg_addr_t S7   = 5'd23;
  localparam reg_addr_t T8   = 5'd24;
  localparam reg_addr_t T9   = 5'd25;
  localparam reg_addr_t K0   = 5'd26;
  localparam reg_addr_t K1   = 5'd27;
  localparam reg_addr_t GP   = 5'd28;
  localparam reg_addr_t SP   = 5'd29;
  localparam reg_addr_t FP   = 5'd30;
  localparam reg_addr_t RA   = 5'd31;

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-writeback scoreboard: one set/clear flop per register.
// Issue sets a bit, writeback clears it; issue wins when both hit the
// same register in one cycle. Register 0 is never pending.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = DEF_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                iss_en,
  input  logic [ADDR_W-1:0]   iss_addr,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  output logic [NUM_REGS-1:0] busy_vec
);

  // Per-register pending bits with issue-over-writeback priority
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_vec <= '0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        if (r == REG_ZERO) begin
          busy_vec[r] <= 1'b0;
        end else if (iss_en && (iss_addr == ADDR_W'(r))) begin
          busy_vec[r] <= 1'b1;
        end else if (wr_en && (wr_addr == ADDR_W'(r))) begin
          busy_vec[r] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// General-purpose register file with NUM_RD combinational read ports,
// one write port, hardwired-zero register 0 and a pending scoreboard
// for RAW hazard detection in decode.
// Optional macro REGFILE_BYPASS_EN: forward a same-cycle writeback to
// matching read ports and mask their pending bit.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int NUM_REGS = DEF_NUM_REGS,
  parameter  int NUM_RD   = 2,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_pend,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  output logic [NUM_REGS-1:0]      busy_vec
);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wrHit;

  // A writeback to register 0 is dropped entirely
  assign wrHit = wr_en && (wr_addr != ADDR_W'(REG_ZERO));

  // Architectural storage; register 0 is never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        mem[r] <= '0;
      end
    end else if (wrHit) begin
      mem[wr_addr] <= wr_data;
    end
  end

  regfile_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .busy_vec (busy_vec)
  );

  // Independent combinational read ports
  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] stored;

    assign addr   = rd_addr[i*ADDR_W +: ADDR_W];
    assign stored = (addr == ADDR_W'(REG_ZERO)) ? '0 : mem[addr];

`ifdef REGFILE_BYPASS_EN
    logic fwd;
    logic issHit;

    // Write-through: the WB value reaches ID in the same cycle
    assign fwd    = wrHit && (wr_addr == addr);
    assign issHit = iss_en && (iss_addr == addr);
    assign rd_data[i*DATA_W +: DATA_W] = fwd ? wr_data : stored;
    assign rd_pend[i] = busy_vec[addr] && !(fwd && !issHit);
`else
    assign rd_data[i*DATA_W +: DATA_W] = stored;
    assign rd_pend[i] = busy_vec[addr];
`endif
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Randomized self-checking bench for regfile_sb against an array model.
module tb_regfile_sb;

  localparam int DW  = 32, NR  = 32, RD  = 2, AW  = 5;
  localparam int DW2 = 64, NR2 = 16, RD2 = 3, AW2 = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [RD*AW-1:0]  rd_addr;
  logic [RD*DW-1:0]  rd_data;
  logic [RD-1:0]     rd_pend;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic              iss_en;
  logic [AW-1:0]     iss_addr;
  logic [NR-1:0]     busy_vec;

  logic               reset2;
  logic [RD2*AW2-1:0] rd_addr2;
  logic [RD2*DW2-1:0] rd_data2;
  logic [RD2-1:0]     rd_pend2;
  logic               wr_en2;
  logic [AW2-1:0]     wr_addr2;
  logic [DW2-1:0]     wr_data2;
  logic               iss_en2;
  logic [AW2-1:0]     iss_addr2;
  logic [NR2-1:0]     busy_vec2;

  int nCmp  = 0;
  int nFail = 0;

  logic [DW-1:0]  mRegs  [NR];
  bit             mBusy  [NR];
  logic [DW2-1:0] mRegs2 [NR2];
  bit             mBusy2 [NR2];

  regfile_sb #(.DATA_W(DW), .NUM_REGS(NR), .NUM_RD(RD)) dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_pend(rd_pend), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .busy_vec(busy_vec)
  );

  regfile_sb #(.DATA_W(DW2), .NUM_REGS(NR2), .NUM_RD(RD2)) dut2 (
    .clk(clk), .reset(reset2), .rd_addr(rd_addr2), .rd_data(rd_data2),
    .rd_pend(rd_pend2), .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2),
    .iss_en(iss_en2), .iss_addr(iss_addr2), .busy_vec(busy_vec2)
  );

  // Advance one edge and apply the architectural rules to the model
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int r = 0; r < NR; r++) begin mRegs[r] = '0; mBusy[r] = 1'b0; end
    end else begin
      if (wr_en && wr_addr != 0) mRegs[wr_addr] = wr_data;
      if (wr_en) mBusy[wr_addr] = 1'b0;
      if (iss_en) mBusy[iss_addr] = 1'b1;
      mBusy[0] = 1'b0;
    end
    if (reset2) begin
      for (int r = 0; r < NR2; r++) begin mRegs2[r] = '0; mBusy2[r] = 1'b0; end
    end else begin
      if (wr_en2 && wr_addr2 != 0) mRegs2[wr_addr2] = wr_data2;
      if (wr_en2) mBusy2[wr_addr2] = 1'b0;
      if (iss_en2) mBusy2[iss_addr2] = 1'b1;
      mBusy2[0] = 1'b0;
    end
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; wr_en = 1'b0; iss_en = 1'b0;
    wr_addr = '0; wr_data = '0; iss_addr = '0;
  endtask

  function automatic logic [RD*DW-1:0] expRdAll();
    logic [RD*DW-1:0] v;
    logic [AW-1:0] a;
    for (int i = 0; i < RD; i++) begin
      a = rd_addr[i*AW +: AW];
      v[i*DW +: DW] = (a == 0) ? '0 : mRegs[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr != 0 && wr_addr == a) v[i*DW +: DW] = wr_data;
`endif
    end
    return v;
  endfunction

  function automatic logic [RD-1:0] expPendAll();
    logic [RD-1:0] v;
    logic [AW-1:0] a;
    for (int i = 0; i < RD; i++) begin
      a = rd_addr[i*AW +: AW];
      v[i] = mBusy[a];
`ifdef REGFILE_BYPASS_EN
      if (wr_en && wr_addr != 0 && wr_addr == a && !(iss_en && iss_addr == a)) v[i] = 1'b0;
`endif
    end
    return v;
  endfunction

  function automatic logic [NR-1:0] expBusy();
    logic [NR-1:0] v;
    for (int r = 0; r < NR; r++) v[r] = mBusy[r];
    return v;
  endfunction

  task automatic test_reset();
    idle(); rd_addr = {5'd5, 5'd5}; #1;
    nCmp++; if (busy_vec !== '0) begin nFail++; $display("FAIL reset_initial_busy: got %h want 0", busy_vec); end
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h1234; tick();
    idle(); iss_en = 1'b1; iss_addr = 5'd5; tick();
    idle(); rd_addr = {5'd5, 5'd5}; #1;
    nCmp++; if (rd_data[31:0] !== 32'h1234) begin nFail++; $display("FAIL reset_preload: got %h want 00001234", rd_data[31:0]); end
    nCmp++; if (busy_vec[5] !== 1'b1) begin nFail++; $display("FAIL reset_prepend: got %b want 1", busy_vec[5]); end
    reset = 1'b1; wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'hBAD0; iss_en = 1'b1; iss_addr = 5'd7; tick();
    idle(); rd_addr = {5'd6, 5'd5}; #1;
    nCmp++; if (rd_data !== '0) begin nFail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    nCmp++; if (busy_vec !== '0) begin nFail++; $display("FAIL reset_busy: got %h want 0", busy_vec); end
    nCmp++; if (rd_pend !== '0) begin nFail++; $display("FAIL reset_rd_pend: got %b want 00", rd_pend); end
  endtask

  task automatic test_write_read();
    idle(); wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'hDEADBEEF; tick();
    idle(); rd_addr = {5'd8, 5'd8}; #1;
    nCmp++; if (rd_data !== {2{32'hDEADBEEF}}) begin nFail++; $display("FAIL wr_rd_r8: got %h want deadbeefdeadbeef", rd_data); end
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFFFFFF; tick();
    idle(); rd_addr = {5'd0, 5'd0}; #1;
    nCmp++; if (rd_data !== '0) begin nFail++; $display("FAIL wr_rd_r0: got %h want 0", rd_data); end
    nCmp++; if (busy_vec !== expBusy()) begin nFail++; $display("FAIL wr_rd_busy: got %h want %h", busy_vec, expBusy()); end
  endtask

  task automatic test_scoreboard();
    idle(); iss_en = 1'b1; iss_addr = 5'd9; tick();
    idle(); rd_addr = {5'd9, 5'd3}; #1;
    nCmp++; if (busy_vec[9] !== 1'b1) begin nFail++; $display("FAIL sb_set: got %b want 1", busy_vec[9]); end
    nCmp++; if (rd_pend !== {1'b1, mBusy[3]}) begin nFail++; $display("FAIL sb_rd_pend: got %b want %b", rd_pend, {1'b1, mBusy[3]}); end
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'd7; tick();
    idle(); rd_addr = {5'd9, 5'd3}; #1;
    nCmp++; if (busy_vec[9] !== 1'b0) begin nFail++; $display("FAIL sb_clear: got %b want 0", busy_vec[9]); end
    nCmp++; if (rd_data[63:32] !== 32'd7) begin nFail++; $display("FAIL sb_wb_data: got %h want 7", rd_data[63:32]); end
    nCmp++; if (rd_pend[1] !== 1'b0) begin nFail++; $display("FAIL sb_pend_clear: got %b want 0", rd_pend[1]); end
  endtask

  task automatic test_collision();
    idle(); iss_en = 1'b1; iss_addr = 5'd10; wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'hCAFE; tick();
    idle(); rd_addr = {5'd10, 5'd10}; #1;
    nCmp++; if (busy_vec[10] !== 1'b1) begin nFail++; $display("FAIL coll_busy: got %b want 1", busy_vec[10]); end
    nCmp++; if (rd_data[31:0] !== 32'hCAFE) begin nFail++; $display("FAIL coll_data: got %h want cafe", rd_data[31:0]); end
    nCmp++; if (rd_pend !== 2'b11) begin nFail++; $display("FAIL coll_pend: got %b want 11", rd_pend); end
    iss_en = 1'b1; iss_addr = 5'd0; tick();
    idle(); rd_addr = {5'd0, 5'd10}; #1;
    nCmp++; if (busy_vec[0] !== 1'b0) begin nFail++; $display("FAIL iss_r0: got %b want 0", busy_vec[0]); end
    nCmp++; if (busy_vec !== expBusy()) begin nFail++; $display("FAIL iss_r0_vec: got %h want %h", busy_vec, expBusy()); end
  endtask

  task automatic test_bypass();
    logic [DW-1:0] want;
    idle(); wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'h1111; tick();
    wr_data = 32'hA5A5; rd_addr = {5'd11, 5'd11}; #1;
`ifdef REGFILE_BYPASS_EN
    want = 32'hA5A5;
`else
    want = 32'h1111;
`endif
    nCmp++; if (rd_data[31:0] !== want) begin nFail++; $display("FAIL bypass_same: got %h want %h", rd_data[31:0], want); end
    nCmp++; if (rd_pend !== 2'b00) begin nFail++; $display("FAIL bypass_pend: got %b want 00", rd_pend); end
    tick();
    idle(); #1;
    nCmp++; if (rd_data[63:32] !== 32'hA5A5) begin nFail++; $display("FAIL bypass_next: got %h want a5a5", rd_data[63:32]); end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      reset    = ($urandom_range(0, 59) == 0);
      wr_en    = $urandom_range(0, 1);
      wr_addr  = ($urandom_range(0, 7) == 0) ? 5'd0 : AW'($urandom_range(0, NR-1));
      wr_data  = $urandom;
      iss_en   = $urandom_range(0, 1);
      iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NR-1));
      for (int i = 0; i < RD; i++)
        rd_addr[i*AW +: AW] = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, NR-1));
      #1;
      nCmp++; if (rd_data !== expRdAll()) begin nFail++; $display("FAIL rand_rd_data c=%0d: got %h want %h", c, rd_data, expRdAll()); end
      nCmp++; if (rd_pend !== expPendAll()) begin nFail++; $display("FAIL rand_rd_pend c=%0d: got %b want %b", c, rd_pend, expPendAll()); end
      nCmp++; if (busy_vec !== expBusy()) begin nFail++; $display("FAIL rand_busy c=%0d: got %h want %h", c, busy_vec, expBusy()); end
      tick();
    end
    idle();
  endtask

  task automatic test_param();
    logic [RD2*DW2-1:0] want;
    logic [AW2-1:0] a;
    rd_addr2 = '0;
    for (int r = 0; r < NR2; r++) begin
      wr_en2 = 1'b1; wr_addr2 = AW2'(r); wr_data2 = {$urandom, $urandom}; tick();
    end
    wr_en2 = 1'b0; iss_en2 = 1'b1; iss_addr2 = 4'd15; tick();
    iss_en2 = 1'b0; rd_addr2 = {4'd15, 4'd15, 4'd15}; #1;
    nCmp++; if (rd_data2 !== {3{mRegs2[15]}}) begin nFail++; $display("FAIL param_r15: got %h want %h", rd_data2, {3{mRegs2[15]}}); end
    nCmp++; if (busy_vec2 !== 16'h8000) begin nFail++; $display("FAIL param_busy: got %h want 8000", busy_vec2); end
    nCmp++; if (rd_pend2 !== 3'b111) begin nFail++; $display("FAIL param_pend: got %b want 111", rd_pend2); end
    rd_addr2 = {4'd0, 4'd1, 4'd14}; #1;
    nCmp++; if (rd_data2 !== {64'd0, mRegs2[1], mRegs2[14]}) begin nFail++; $display("FAIL param_r0: got %h want %h", rd_data2, {64'd0, mRegs2[1], mRegs2[14]}); end
    for (int k = 0; k < 20; k++) begin
      for (int i = 0; i < RD2; i++) begin
        a = AW2'($urandom_range(0, NR2-1));
        rd_addr2[i*AW2 +: AW2] = a;
        want[i*DW2 +: DW2] = (a == 0) ? '0 : mRegs2[a];
      end
      #1;
      nCmp++; if (rd_data2 !== want) begin nFail++; $display("FAIL param_rand k=%0d: got %h want %h", k, rd_data2, want); end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
    reset2 = 1'b1; wr_en2 = 1'b0; wr_addr2 = '0; wr_data2 = '0;
    iss_en2 = 1'b0; iss_addr2 = '0; rd_addr2 = '0;
    tick(); tick();
    reset = 1'b0; reset2 = 1'b0;
    test_reset();
    test_write_read();
    test_scoreboard();
    test_collision();
    test_bypass();
    test_random();
    test_param();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
Parametrised successor to the pipeline's general-purpose register file.
- Clocked, synchronous-reset storage with NUM_RD combinational read ports and one write port.
- Register 0 is hardwired to zero.
- A per-register pending scoreboard lets the decode stage detect RAW hazards on registers awaiting writeback.
- Sits between ID (reads, issue) and WB (write, scoreboard clear).

Parameters:
DATA_W, 32, register width in bits
NUM_REGS, 32, number of architectural registers (power of two, >=2)
NUM_RD, 2, number of read ports (>=1)
ADDR_W, $clog2(NUM_REGS), address width (derived, not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i at [i*ADDR_W +: ADDR_W]
rd_data  out  NUM_RD*DATA_W  packed read data, combinational
rd_pend  out  NUM_RD  per-port scoreboard pending bit for the addressed register
wr_en  in  1  writeback enable
wr_addr  in  ADDR_W  writeback destination
wr_data  in  DATA_W  writeback data
iss_en  in  1  issue: mark iss_addr pending
iss_addr  in  ADDR_W  destination of the issuing instruction
busy_vec  out  NUM_REGS  full scoreboard, bit r = register r pending

Behaviour:
- Reset is synchronous and active-high on clk, named as elsewhere in the codebase (clk, reset). While reset is sampled high, all registers and all scoreboard bits clear to 0 on the edge; wr_en and iss_en are ignored in that cycle.
- Reset mid-operation discards in-flight pending state.
- rd_data and rd_pend are combinational from rd_addr and state, so they show 0 during and after reset.
- Write: on the edge with wr_en=1 and wr_addr!=0, mem[wr_addr] <= wr_data. A write to address 0 is dropped.
- Read: rd_data[i] = 0 if rd_addr[i]==0, else mem[rd_addr[i]] (plus bypass, see Optional Feature). Read latency is 0 cycles. The registered write is visible from the cycle after the write edge.
- Scoreboard, per register r!=0, next state:
  - iss_en && iss_addr==r -> 1
  - else wr_en && wr_addr==r -> 0
  - else hold
- Simultaneous issue and write to the same register: issue wins, bit stays 1 (a newer producer supersedes the older one).
- Issue or write to register 0 never sets a bit; busy_vec[0] is constantly 0.
- Writeback to a non-pending register is legal: data is written, bit stays 0.
- rd_pend[i] = busy_vec[rd_addr[i]], evaluated before the current edge (no bypass of the scoreboard).
- All read ports are independent; identical addresses on several ports return identical data.
- No other state machine: the scoreboard is NUM_REGS independent 1-bit set/clear flops.

Optional Feature:
Macro REGFILE_BYPASS_EN.
- Defined: write-through forwarding. If wr_en=1, wr_addr!=0 and wr_addr==rd_addr[i], rd_data[i]=wr_data in the same cycle, and rd_pend[i]=0 unless iss_en=1 && iss_addr==rd_addr[i]. This removes the WB->ID half-cycle dependency.
- Undefined: reads return stored state only. A same-cycle write is visible the next cycle.

Decomposition:
- Shared package regfile_pkg holds:
  - DATA_W and NUM_REGS defaults
  - localparam REG_ZERO = 0
  - MIPS register-name constants: ZERO, AT, V0..V1, A0..A3, T0..T9, S0..S7, K0..K1, GP, SP, FP, RA
  - typedef reg_addr_t (ADDR_W bits)
- One sub-module, regfile_scoreboard: NUM_REGS pending flops, issue/clear priority and busy_vec output.
- Storage and read muxing stay in regfile_sb.

Test Plan:
- Reset: preload r5=0x1234 and pend r5, assert reset 1 cycle -> next cycle rd_data(r5)=0, busy_vec=0. A wr_en in the reset cycle is ignored.
- Write/read: write r8=0xDEADBEEF, then read r8 on both ports next cycle -> both 0xDEADBEEF. Write r0=0xFFFFFFFF -> r0 reads 0.
- Scoreboard: issue r9 -> busy_vec[9]=1 and rd_pend=1 on a port reading r9. Writeback r9=7 -> bit clears next cycle, data 7.
- Collision: issue r10 and write r10 in the same cycle -> busy_vec[10]=1 after the edge, mem[10] updated. Issue r0 -> busy_vec[0]=0.
- Bypass (REGFILE_BYPASS_EN defined): wr r11=0xA5A5 and read r11 in the same cycle -> rd_data=0xA5A5, rd_pend=0. Without the macro -> old value that cycle, 0xA5A5 the next.
- Parametrisation: NUM_REGS=16, NUM_RD=3, DATA_W=64 -> write/read across all 3 ports, address 15 wraps correctly, no out-of-range access.
